// File: rtl/avl_port_arbiter_pkg.sv
// Shared constants and helpers for the Avalon-MM port arbiter and its read-tag FIFO.
package avl_port_arbiter_pkg;

  localparam logic [2:0] AVL_SIZE_SINGLE = 3'd1;

  // Bits needed to hold a requester index; never narrower than one bit.
  function automatic int req_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avl_port_arbiter_tag_fifo.sv
// Synchronous FIFO of requester tags for outstanding reads; push and pop may coincide at any level.
module avl_port_arbiter_tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/avl_port_arbiter.sv
// Shares one Avalon-MM DDR2 port among NUM_REQ line requesters with in-order read return routing.
// Build option: define AVL_ARB_FIXED_PRIO_EN to give requester 0 priority over a round-robin group.
module avl_port_arbiter
  import avl_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BE_WIDTH   = 32,
  parameter int MAX_OUTST  = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_rw,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*LINE_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ*BE_WIDTH-1:0]    req_be,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [LINE_WIDTH-1:0]          rsp_data,
  output logic                           err_orphan,
  input  logic                           avl_ready,
  output logic [ADDR_WIDTH-1:0]          avl_addr,
  output logic [2:0]                     avl_size,
  output logic [LINE_WIDTH-1:0]          avl_wdata,
  output logic [BE_WIDTH-1:0]            avl_be,
  output logic                           avl_write_req,
  output logic                           avl_read_req,
  output logic                           avl_burstbegin,
  input  logic [LINE_WIDTH-1:0]          avl_rdata,
  input  logic                           avl_rdata_valid
);
  localparam int IW = req_idx_w(NUM_REQ);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  logic                  run_q, run_d;
  logic                  held_q, held_d;
  logic [IW-1:0]         gnt_q, gnt_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [LINE_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  err_orphan_q, err_orphan_d;

  logic [NUM_REQ-1:0]    elig;
  logic [IW-1:0]         sel, cand, fifo_head;
  logic [CW-1:0]         fifo_count;
  logic                  cmd_valid, hit, sel_rw, accept, push, pop;
  logic                  fifo_full, fifo_nonempty;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] cur, input logic [IW-1:0] wrap_to);
    return (cur == LAST_IDX) ? wrap_to : cur + IW'(1);
  endfunction

  // Occupancy is the registered count, so a same-cycle return does not unblock a read.
  always_comb begin
    fifo_full     = (fifo_count == CW'(MAX_OUTST));
    fifo_nonempty = (fifo_count != '0);
    elig          = req_valid & (req_rw | {NUM_REQ{~fifo_full}});
  end

  // Winner selection; a stalled command keeps its grant until the controller takes it.
  always_comb begin
    sel       = gnt_q;
    cmd_valid = 1'b0;
    hit       = 1'b0;
    cand      = rr_ptr_q;
    if (!run_q) begin
      cmd_valid = 1'b0;
    end else if (held_q) begin
      cmd_valid = req_valid[gnt_q];
    end else begin
`ifdef AVL_ARB_FIXED_PRIO_EN
      if (elig[0]) begin
        sel       = '0;
        cmd_valid = 1'b1;
      end else begin
        cand = (rr_ptr_q == '0) ? IW'(1) : rr_ptr_q;
        for (int i = 0; i < NUM_REQ - 1; i++) begin
          hit       = ~cmd_valid & elig[cand];
          sel       = hit ? cand : sel;
          cmd_valid = cmd_valid | hit;
          cand      = next_idx(cand, IW'(1));
        end
      end
`else
      for (int i = 0; i < NUM_REQ; i++) begin
        hit       = ~cmd_valid & elig[cand];
        sel       = hit ? cand : sel;
        cmd_valid = cmd_valid | hit;
        cand      = next_idx(cand, '0);
      end
`endif
    end
  end

  // Winner's fields go straight to the controller; reads always carry full byte enables.
  always_comb begin
    sel_rw         = req_rw[sel];
    avl_read_req   = cmd_valid & ~sel_rw;
    avl_write_req  = cmd_valid & sel_rw;
    avl_burstbegin = cmd_valid;
    avl_size       = AVL_SIZE_SINGLE;
    avl_addr       = req_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
    avl_wdata      = req_wdata[int'(sel)*LINE_WIDTH +: LINE_WIDTH];
    avl_be         = sel_rw ? req_be[int'(sel)*BE_WIDTH +: BE_WIDTH] : {BE_WIDTH{1'b1}};
    accept         = cmd_valid & avl_ready;
    req_ready      = accept ? (NUM_REQ'(1) << sel) : '0;
    push           = accept & ~sel_rw;
    pop            = avl_rdata_valid & fifo_nonempty;
  end

  avl_port_arbiter_tag_fifo #(
    .WIDTH (IW),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (sel),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // Next-state for grant tracking and the one-cycle registered read return.
  always_comb begin
    run_d        = 1'b1;
    held_d       = cmd_valid & ~avl_ready;
    gnt_d        = cmd_valid ? sel : gnt_q;
    rr_ptr_d     = accept ? next_idx(sel, '0) : rr_ptr_q;
    rsp_valid_d  = pop ? (NUM_REQ'(1) << fifo_head) : '0;
    rsp_data_d   = pop ? avl_rdata : rsp_data_q;
    err_orphan_d = err_orphan_q | (avl_rdata_valid & ~fifo_nonempty);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q        <= 1'b0;
      held_q       <= 1'b0;
      gnt_q        <= '0;
      rr_ptr_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      run_q        <= run_d;
      held_q       <= held_d;
      gnt_q        <= gnt_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_avl_port_arbiter.sv
// Directed + randomized bench for avl_port_arbiter with a request-queue / tag-queue reference model.
module tb_avl_port_arbiter;
  localparam int N = 2, AW = 32, LW = 256, BW = 32, MO = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [N-1:0]      req_valid = '0, req_rw = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*LW-1:0]   req_wdata = '0;
  logic [N*BW-1:0]   req_be = '0;
  logic [N-1:0]      req_ready, rsp_valid;
  logic [LW-1:0]     rsp_data;
  logic              err_orphan;
  logic              avl_ready = 1'b0;
  logic [AW-1:0]     avl_addr;
  logic [2:0]        avl_size;
  logic [LW-1:0]     avl_wdata;
  logic [BW-1:0]     avl_be;
  logic              avl_write_req, avl_read_req, avl_burstbegin;
  logic [LW-1:0]     avl_rdata = '0;
  logic              avl_rdata_valid = 1'b0;

  always #5 clk = ~clk;

  avl_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .BE_WIDTH(BW), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .err_orphan(err_orphan), .avl_ready(avl_ready), .avl_addr(avl_addr), .avl_size(avl_size),
    .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_write_req(avl_write_req),
    .avl_read_req(avl_read_req), .avl_burstbegin(avl_burstbegin),
    .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid)
  );

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [BW-1:0] be;
  } cmd_t;

  cmd_t          rq0[$], rq1[$];
  int            tagq[$];
  logic [LW-1:0] memq[$];
  int            rr = 0, locked = -1;
  logic [N-1:0]  exp_rsp_valid = '0;
  logic [LW-1:0] exp_rsp_data = '0;
  logic          exp_orphan = 1'b0;
  bit            ret_en = 1'b0, ret_rand = 1'b0, inject_orphan = 1'b0, ready_rand = 1'b0;
  logic          ready_fixed = 1'b1;
  int            n_checks = 0, n_fails = 0;
  logic [N-1:0]  obs_ready, obs_rsp;
  logic [AW-1:0] obs_addr;
  logic          obs_err;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic cmd_t mk_cmd(input logic rw, input logic [AW-1:0] a);
    cmd_t c;
    c.rw = rw; c.addr = a; c.wdata = rand_line(); c.be = $urandom;
    return c;
  endfunction

  function automatic int q_size(input int i);
    if (i == 0) return rq0.size();
    else return rq1.size();
  endfunction

  function automatic cmd_t q_front(input int i);
    if (i == 0) return rq0[0];
    else return rq1[0];
  endfunction

  function automatic void q_pop(input int i);
    if (i == 0) void'(rq0.pop_front());
    else void'(rq1.pop_front());
  endfunction

  function automatic void q_push(input int i, input cmd_t c);
    if (i == 0) rq0.push_back(c);
    else rq1.push_back(c);
  endfunction

  // A requester may be picked when it has work and, for reads, a tag slot is free.
  function automatic bit elig_m(input int i);
    cmd_t c;
    if (q_size(i) == 0) return 1'b0;
    c = q_front(i);
    return c.rw || (tagq.size() < MO);
  endfunction

  task automatic cycle();
    cmd_t c, cs;
    int sel, idx, t;
    bit cmd, acc, rv;
    logic [N-1:0] exp_ready;
    for (int i = 0; i < N; i++) begin
      if (q_size(i) > 0) begin
        c = q_front(i);
        req_valid[i] = 1'b1; req_rw[i] = c.rw;
        req_addr[i*AW +: AW] = c.addr; req_wdata[i*LW +: LW] = c.wdata; req_be[i*BW +: BW] = c.be;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    avl_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
    rv = 1'b0;
    if (inject_orphan) begin
      rv = 1'b1; avl_rdata = rand_line();
    end else if (ret_en && memq.size() > 0 && (!ret_rand || $urandom_range(0, 2) != 0)) begin
      rv = 1'b1; avl_rdata = memq.pop_front();
    end
    avl_rdata_valid = rv;
    #1;
    sel = 0; cmd = 1'b0;
    if (locked >= 0) begin
      sel = locked; cmd = 1'b1;
    end else begin
`ifdef AVL_ARB_FIXED_PRIO_EN
      if (elig_m(0)) begin
        sel = 0; cmd = 1'b1;
      end else begin
        for (int k = 0; k < N - 1; k++) begin
          idx = 1 + ((((rr == 0) ? 1 : rr) - 1 + k) % (N - 1));
          if (!cmd && elig_m(idx)) begin sel = idx; cmd = 1'b1; end
        end
      end
`else
      for (int k = 0; k < N; k++) begin
        idx = (rr + k) % N;
        if (!cmd && elig_m(idx)) begin sel = idx; cmd = 1'b1; end
      end
`endif
    end
    cs = '0;
    if (cmd) cs = q_front(sel);
    acc = cmd && (avl_ready === 1'b1);
    exp_ready = acc ? (N'(1) << sel) : '0;
    obs_ready = req_ready; obs_rsp = rsp_valid; obs_addr = avl_addr; obs_err = err_orphan;
    chk("req_ready", LW'(req_ready), LW'(exp_ready));
    chk("avl_read_req", LW'(avl_read_req), LW'(cmd && !cs.rw));
    chk("avl_write_req", LW'(avl_write_req), LW'(cmd && cs.rw));
    chk("avl_burstbegin", LW'(avl_burstbegin), LW'(cmd));
    chk("avl_size", LW'(avl_size), LW'(3'd1));
    if (cmd) begin
      chk("avl_addr", LW'(avl_addr), LW'(cs.addr));
      chk("avl_be", LW'(avl_be), cs.rw ? LW'(cs.be) : LW'({BW{1'b1}}));
      if (cs.rw) chk("avl_wdata", avl_wdata, cs.wdata);
    end
    chk("rsp_valid", LW'(rsp_valid), LW'(exp_rsp_valid));
    chk("rsp_data", rsp_data, exp_rsp_data);
    chk("err_orphan", LW'(err_orphan), LW'(exp_orphan));
    // Returns pop the oldest outstanding tag before this cycle's accept is queued.
    exp_rsp_valid = '0;
    if (rv) begin
      if (tagq.size() > 0) begin
        t = tagq.pop_front();
        exp_rsp_valid = N'(1) << t;
        exp_rsp_data = avl_rdata;
      end else begin
        exp_orphan = 1'b1;
      end
    end
    if (acc) begin
      rr = (sel + 1) % N;
      q_pop(sel);
      if (!cs.rw) begin
        tagq.push_back(sel);
        memq.push_back(rand_line());
      end
    end
    locked = (cmd && !acc) ? sel : -1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_req_ready", LW'(req_ready), LW'(0));
    chk("rst_read_req", LW'(avl_read_req), LW'(0));
    chk("rst_write_req", LW'(avl_write_req), LW'(0));
    chk("rst_burstbegin", LW'(avl_burstbegin), LW'(0));
    chk("rst_rsp_valid", LW'(rsp_valid), LW'(0));
    chk("rst_rsp_data", rsp_data, LW'(0));
    chk("rst_err_orphan", LW'(err_orphan), LW'(0));
    rq0.delete(); rq1.delete(); tagq.delete(); memq.delete();
    rr = 0; locked = -1; exp_rsp_valid = '0; exp_rsp_data = '0; exp_orphan = 1'b0;
    inject_orphan = 1'b0; avl_rdata_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Simultaneous reads from both requesters after reset.
    ready_fixed = 1'b1; ret_en = 1'b1; ret_rand = 1'b0;
    q_push(0, mk_cmd(1'b0, 32'h100));
    q_push(1, mk_cmd(1'b0, 32'h200));
    cycle();
    chk("t1_first_grant", LW'(obs_ready), LW'(2'b01));
    chk("t1_first_addr", LW'(obs_addr), LW'(32'h100));
    cycle();
    chk("t1_second_grant", LW'(obs_ready), LW'(2'b10));
    chk("t1_second_addr", LW'(obs_addr), LW'(32'h200));
    cycle();
    chk("t1_rsp_r0", LW'(obs_rsp), LW'(2'b01));
    cycle();
    chk("t1_rsp_r1", LW'(obs_rsp), LW'(2'b10));
    cycle();

    // Write stalled by the controller for four cycles.
    ready_fixed = 1'b0;
    q_push(1, mk_cmd(1'b1, 32'h300));
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t2_addr_hold", LW'(obs_addr), LW'(32'h300));
      chk("t2_no_ready", LW'(obs_ready), LW'(0));
    end
    ready_fixed = 1'b1;
    cycle();
    chk("t2_accept", LW'(obs_ready), LW'(2'b10));

    // Fill the tag FIFO; writes still pass, one return unblocks the ninth read.
    ret_en = 1'b0;
    for (int k = 0; k < 9; k++) q_push(0, mk_cmd(1'b0, 32'h1000 + k));
    for (int k = 0; k < 8; k++) cycle();
    cycle();
    chk("t3_read_stalled", LW'(obs_ready), LW'(0));
    q_push(1, mk_cmd(1'b1, 32'h40));
    cycle();
    chk("t3_write_passes", LW'(obs_ready), LW'(2'b10));
    ret_en = 1'b1;
    cycle();
    chk("t3_full_same_cycle", LW'(obs_ready), LW'(0));
    ret_en = 1'b0;
    cycle();
    chk("t3_ninth_read", LW'(obs_ready), LW'(2'b01));
    ret_en = 1'b1;
    for (int k = 0; k < 12; k++) cycle();

    // Push and pop together near and at the occupancy limit.
    ret_en = 1'b0;
    for (int k = 0; k < 7; k++) q_push(0, mk_cmd(1'b0, 32'h2000 + k));
    for (int k = 0; k < 7; k++) cycle();
    q_push(0, mk_cmd(1'b0, 32'h2100));
    q_push(1, mk_cmd(1'b0, 32'h2200));
    q_push(1, mk_cmd(1'b0, 32'h2300));
    ret_en = 1'b1;
    for (int k = 0; k < 16; k++) cycle();
    for (int k = 0; k < 20 && tagq.size() > 0; k++) cycle();
    chk("t4_drained", LW'(tagq.size()), LW'(0));

    // Return with nothing outstanding.
    inject_orphan = 1'b1;
    cycle();
    inject_orphan = 1'b0;
    cycle();
    chk("t5_orphan_set", LW'(obs_err), LW'(1));
    chk("t5_no_rsp", LW'(obs_rsp), LW'(0));
    for (int k = 0; k < 3; k++) cycle();
    chk("t5_orphan_sticky", LW'(obs_err), LW'(1));
    do_reset();

    // Continuous reads from both, then reset mid-burst.
    ret_en = 1'b1; ret_rand = 1'b1;
    for (int k = 0; k < 10; k++) begin
      q_push(0, mk_cmd(1'b0, 32'h3000 + k));
      q_push(1, mk_cmd(1'b0, 32'h4000 + k));
    end
    for (int k = 0; k < 12; k++) cycle();
    do_reset();

    // Randomized traffic with random controller stalls and return spacing.
    ready_rand = 1'b1; ret_en = 1'b1; ret_rand = 1'b1;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (q_size(i) < 3 && $urandom_range(0, 2) == 0)
          q_push(i, mk_cmd(1'($urandom_range(0, 1)), $urandom));
      end
      cycle();
    end
    ready_rand = 1'b0; ready_fixed = 1'b1; ret_rand = 1'b0;
    for (int k = 0; k < 100 && (rq0.size() + rq1.size() + tagq.size() + memq.size()) > 0; k++) cycle();
    cycle();
    chk("rand_drained", LW'(rq0.size() + rq1.size() + tagq.size()), LW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
